// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop-synchronised push-button debouncer (optional DEBOUNCE_BOUNCE_CNT_EN bounce counter)
module button_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in,
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    output logic [7:0] bounce_count,
`endif
    output logic       out
);

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   out_q;
    logic                   abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // A sample opposite to the level being qualified ends the qualification.
    assign abort = ((state_q == CHECK_HIGH) && !sync_bit) ||
                   ((state_q == CHECK_LOW)  &&  sync_bit);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE_LOW: begin
                    if (sync_bit) begin
                        state_q <= CHECK_HIGH;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                CHECK_HIGH: begin
                    if (!sync_bit) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        out_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_bit) begin
                        state_q <= CHECK_LOW;
                        cnt_q   <= CNT_ONE;
                    end
                end
                CHECK_LOW: begin
                    if (sync_bit) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        out_q   <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out = out_q;

`ifdef DEBOUNCE_BOUNCE_CNT_EN
    logic [7:0] bounce_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            bounce_q <= '0;
        end else if (abort && (bounce_q != 8'hFF)) begin
            bounce_q <= bounce_q + 8'd1;
        end
    end

    assign bounce_count = bounce_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed bench for button_debouncer with a run-length reference model
`timescale 1ns/1ps
module tb_button_debouncer;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int HIST          = 4096;

    logic       clock;
    logic       reset;
    logic       din;
    logic       dout;
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    logic [7:0] bounce_count;
`endif

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in          (din),
`ifdef DEBOUNCE_BOUNCE_CNT_EN
        .bounce_count(bounce_count),
`endif
        .out         (dout)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw input levels are logged per edge; the level the decision logic
    // sees on edge e is the raw level from edge e-SYNC_STAGES (zero if that
    // precedes the last reset). out flips after STABLE_CYCLES consecutive
    // opposite samples; a shorter opposite run that is broken counts a bounce.
    bit   raw_hist [HIST];
    int   edge_n   = 0;
    int   last_rst = 0;
    int   run      = 0;
    bit   m_out    = 1'b0;
    int   m_bc     = 0;

    always @(posedge clock) begin
        bit s;
        edge_n++;
        raw_hist[edge_n] = din;
        if (reset) begin
            last_rst = edge_n;
            m_out    = 1'b0;
            run      = 0;
            m_bc     = 0;
        end else begin
            s = (edge_n - SYNC_STAGES > last_rst) ? raw_hist[edge_n - SYNC_STAGES] : 1'b0;
            if (s != m_out) begin
                run++;
                if (run == STABLE_CYCLES) begin
                    m_out = s;
                    run   = 0;
                end
            end else begin
                if (run > 0 && m_bc < 255) m_bc++;
                run = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (edge_n >= 1) begin
            check("out_vs_model", {7'd0, dout}, {7'd0, m_out});
`ifdef DEBOUNCE_BOUNCE_CNT_EN
            check("bounce_vs_model", bounce_count, 8'(m_bc));
`endif
        end
    end

    task automatic wait_until(input int t);
        if (t > $time) #(t - $time);
    endtask

    task automatic lit(input string name, input bit exp_out);
        check({name, "_dut"}, {7'd0, dout}, {7'd0, exp_out});
        check({name, "_model"}, {7'd0, m_out}, {7'd0, exp_out});
    endtask

    task automatic lit_bc(input string name, input int exp_bc);
`ifdef DEBOUNCE_BOUNCE_CNT_EN
        check({name, "_dut"}, bounce_count, 8'(exp_bc));
`endif
        check({name, "_model"}, 8'(m_bc), 8'(exp_bc));
    endtask

    typedef struct {
        bit lvl;
        int dur;
    } seg_t;

    seg_t segs[10] = '{
        '{1'b0, 30}, '{1'b1, 10}, '{1'b0, 50}, '{1'b1, 130}, '{1'b0, 20},
        '{1'b1, 30}, '{1'b0, 200}, '{1'b1, 20}, '{1'b0, 5},  '{1'b1, 150}
    };

    initial begin
        reset = 1'b1;
        din   = 1'b0;

        // Clean press: first sampling edge 30 ns, out rises on the 130 ns edge.
        wait_until(15);  reset = 1'b0; din = 1'b1;
        wait_until(120); lit("press_before", 1'b0);
        wait_until(140); lit("press_after", 1'b1);

        // Clean release: first sampling edge 150 ns, out falls on the 250 ns edge.
        wait_until(145); din = 1'b0;
        wait_until(240); lit("release_before", 1'b1);
        wait_until(260); lit("release_after", 1'b0);

        // Glitch between edges is never sampled.
        wait_until(265); din = 1'b1;
        wait_until(267); din = 1'b0;
        wait_until(400); lit("glitch_out", 1'b0);
        lit_bc("glitch_bc", 0);

        // Bounce on press: qualification aborts, restart on the 490 ns edge.
        wait_until(405); din = 1'b1;
        wait_until(445); din = 1'b0;
        wait_until(485); din = 1'b1;
        wait_until(580); lit("bounce_before", 1'b0);
        wait_until(600); lit("bounce_after", 1'b1);
        lit_bc("bounce_bc", 1);

        // Release with a one-cycle return high: restart from the 670 ns edge.
        wait_until(605); din = 1'b0;
        wait_until(645); din = 1'b1;
        wait_until(665); din = 1'b0;
        wait_until(760); lit("restart_before", 1'b1);
        wait_until(780); lit("restart_after", 1'b0);
        lit_bc("restart_bc", 2);

        // Reset during CHECK_HIGH.
        wait_until(785); din = 1'b1;
        wait_until(855); reset = 1'b1;
        wait_until(875); reset = 1'b0;
        wait_until(880); lit_bc("rst_check_bc", 0);
        wait_until(980); lit("rst_check_before", 1'b0);
        wait_until(1000); lit("rst_check_after", 1'b1);

        // Reset while out=1 with in held high.
        wait_until(1005); reset = 1'b1;
        wait_until(1020); lit("rst_high_on_edge", 1'b0);
        wait_until(1025); reset = 1'b0;
        wait_until(1120); lit("rst_high_before", 1'b0);
        wait_until(1140); lit("rst_high_after", 1'b1);

        // Mixed bounce pattern, checked against the model only.
        wait_until(1145);
        for (int i = 0; i < 10; i++) begin
            din = segs[i].lvl;
            #(segs[i].dur);
        end
        #300;
        lit("final_level", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
